// File: rtl/nibble_sort_pkg.sv
// Shared types and constants for the 4-element nibble sorter:
// FSM states, element/step counts and the step-to-pair index table.
package nibble_sort_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SORT,
        ST_DONE
    } state_e;

    localparam int unsigned NUM_ELEM  = 4;
    localparam int unsigned NUM_STEPS = 6;
    localparam logic [2:0]  LAST_STEP = 3'(NUM_STEPS - 1);

    // Lower index of the compared pair for each step; the upper index is always lower+1.
    function automatic logic [1:0] pair_lo(input logic [2:0] step);
        logic [1:0] lo;
        case (step)
            3'd0:    lo = 2'd0;
            3'd1:    lo = 2'd1;
            3'd2:    lo = 2'd2;
            3'd3:    lo = 2'd0;
            3'd4:    lo = 2'd1;
            3'd5:    lo = 2'd0;
            default: lo = 2'd0;
        endcase
        return lo;
    endfunction

endpackage

// File: rtl/nibble_sort_ctrl_cmp4_unit.sv
// Combinational unsigned 4-bit magnitude comparator: exactly one of
// low (a<b), equal (a==b) or great (a>b) is asserted.
module cmp4_unit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       low,
    output logic       equal,
    output logic       great
);

    always_comb begin
        low   = (a < b);
        equal = (a == b);
        great = (a > b);
    end

endmodule

// File: rtl/nibble_sort_ctrl.sv
// Sequential 4-nibble sorting network controller: one compare-swap per clock
// through a fixed 6-step pair sequence, results published only on completion.
module nibble_sort_ctrl
    import nibble_sort_pkg::*;
#(
    parameter int DESCEND = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] din,
    output logic        busy,
    output logic        done,
    output logic [15:0] dout,
    output logic [2:0]  swap_count,
    output logic        dup
);

    state_e      state_q;
    logic [15:0] work_q;
    logic [2:0]  step_q;
    logic [2:0]  swaps_q;
    logic        dupacc_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] dout_q;
    logic [2:0]  swap_count_q;
    logic        dup_q;

    logic [15:0] work_d;
    logic [2:0]  swaps_d;
    logic        dupacc_d;

    logic [3:0]  elem [NUM_ELEM];
    logic [3:0]  sorted [NUM_ELEM];
    logic [1:0]  lo_idx;
    logic [1:0]  hi_idx;
    logic [3:0]  cmp_a;
    logic [3:0]  cmp_b;
    logic        cmp_low;
    logic        cmp_equal;
    logic        cmp_great;
    logic        do_swap;

    always_comb begin
        for (int unsigned i = 0; i < NUM_ELEM; i++) begin
            elem[i] = work_q[4*i +: 4];
        end
        lo_idx = pair_lo(step_q);
        hi_idx = lo_idx + 2'd1;
        cmp_a  = elem[lo_idx];
        cmp_b  = elem[hi_idx];
    end

    cmp4_unit u_cmp (
        .a     (cmp_a),
        .b     (cmp_b),
        .low   (cmp_low),
        .equal (cmp_equal),
        .great (cmp_great)
    );

    // Equal pairs never swap in either order, which keeps the sort stable.
    assign do_swap = (DESCEND != 0) ? cmp_low : cmp_great;

    always_comb begin
        sorted = elem;
        if (do_swap) begin
            sorted[lo_idx] = cmp_b;
            sorted[hi_idx] = cmp_a;
        end
        work_d = '0;
        for (int unsigned i = 0; i < NUM_ELEM; i++) begin
            work_d[4*i +: 4] = sorted[i];
        end
        swaps_d  = do_swap ? swaps_q + 3'd1 : swaps_q;
        dupacc_d = dupacc_q | cmp_equal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            work_q       <= '0;
            step_q       <= '0;
            swaps_q      <= '0;
            dupacc_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dout_q       <= '0;
            swap_count_q <= '0;
            dup_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        work_q   <= din;
                        step_q   <= '0;
                        swaps_q  <= '0;
                        dupacc_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_SORT;
                    end
                end
                ST_SORT: begin
                    work_q   <= work_d;
                    swaps_q  <= swaps_d;
                    dupacc_q <= dupacc_d;
                    step_q   <= step_q + 3'd1;
                    // Publish the post-swap values of the final step directly.
                    if (step_q == LAST_STEP) begin
                        dout_q       <= work_d;
                        swap_count_q <= swaps_d;
                        dup_q        <= dupacc_d;
                        done_q       <= 1'b1;
                        state_q      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign dout       = dout_q;
    assign swap_count = swap_count_q;
    assign dup        = dup_q;

endmodule

// File: tb/tb_nibble_sort_ctrl.sv
// Directed bench for nibble_sort_ctrl: ascending and descending instances
// share stimulus and are checked against hand-computed results.
module tb_nibble_sort_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] din;

    logic        busy_a, done_a, dup_a;
    logic [15:0] dout_a;
    logic [2:0]  swc_a;
    logic        busy_d, done_d, dup_d;
    logic [15:0] dout_d;
    logic [2:0]  swc_d;

    int checks = 0;
    int errors = 0;
    logic [15:0] prev_a = 16'h0000;
    logic [15:0] prev_d = 16'h0000;

    nibble_sort_ctrl #(.DESCEND(0)) u_asc (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .din        (din),
        .busy       (busy_a),
        .done       (done_a),
        .dout       (dout_a),
        .swap_count (swc_a),
        .dup        (dup_a)
    );

    nibble_sort_ctrl #(.DESCEND(1)) u_dsc (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .din        (din),
        .busy       (busy_d),
        .done       (done_d),
        .dout       (dout_d),
        .swap_count (swc_d),
        .dup        (dup_d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with both instances idle; returns at the falling
    // edge after the DONE->IDLE edge, so a following call is a back-to-back start.
    task automatic run_sort(input logic [15:0] d, input logic hold,
                            input logic [15:0] ea, input logic [2:0] sa, input logic da,
                            input logic [15:0] ed, input logic [2:0] sd, input logic dd);
        din   = d;
        start = 1'b1;
        @(negedge clk);
        if (hold) din = 16'h0000;
        else      start = 1'b0;
        check("busy_at_start_a", 16'(busy_a), 16'd1);
        check("busy_at_start_d", 16'(busy_d), 16'd1);
        check("done_at_start_a", 16'(done_a), 16'd0);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check("done_early_a", 16'(done_a), 16'd0);
            check("done_early_d", 16'(done_d), 16'd0);
            check("busy_sort_a", 16'(busy_a), 16'd1);
            check("dout_hold_a", dout_a, prev_a);
            check("dout_hold_d", dout_d, prev_d);
        end
        @(negedge clk);
        check("done_pulse_a", 16'(done_a), 16'd1);
        check("done_pulse_d", 16'(done_d), 16'd1);
        check("busy_done_a", 16'(busy_a), 16'd1);
        check("dout_a", dout_a, ea);
        check("swap_count_a", 16'(swc_a), 16'(sa));
        check("dup_a", 16'(dup_a), 16'(da));
        check("dout_d", dout_d, ed);
        check("swap_count_d", 16'(swc_d), 16'(sd));
        check("dup_d", 16'(dup_d), 16'(dd));
        @(negedge clk);
        start = 1'b0;
        check("done_after_a", 16'(done_a), 16'd0);
        check("busy_after_a", 16'(busy_a), 16'd0);
        check("dout_kept_a", dout_a, ea);
        check("swap_count_kept_a", 16'(swc_a), 16'(sa));
        prev_a = ea;
        prev_d = ed;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        din   = 16'h0000;
        #2;
        check("rst_busy", 16'(busy_a), 16'd0);
        check("rst_done", 16'(done_a), 16'd0);
        check("rst_dout", dout_a, 16'h0000);
        check("rst_swap_count", 16'(swc_a), 16'd0);
        check("rst_dup", 16'(dup_a), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_sort(16'hB6E9, 1'b0, 16'hEB96, 3'd3, 1'b0, 16'h69BE, 3'd3, 1'b0);
        run_sort(16'h05AF, 1'b0, 16'hFA50, 3'd6, 1'b0, 16'h05AF, 3'd0, 1'b0);
        run_sort(16'h7777, 1'b0, 16'h7777, 3'd0, 1'b1, 16'h7777, 3'd0, 1'b1);
        run_sort(16'hB6E9, 1'b1, 16'hEB96, 3'd3, 1'b0, 16'h69BE, 3'd3, 1'b0);
        run_sort(16'h05AF, 1'b0, 16'hFA50, 3'd6, 1'b0, 16'h05AF, 3'd0, 1'b0);

        din   = 16'hB6E9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 16'(busy_a), 16'd0);
        check("midrst_done", 16'(done_a), 16'd0);
        check("midrst_dout", dout_a, 16'h0000);
        check("midrst_swap_count", 16'(swc_a), 16'd0);
        check("midrst_dup", 16'(dup_a), 16'd0);
        check("midrst_dout_d", dout_d, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("no_done_after_rst", 16'(done_a), 16'd0);
            check("no_busy_after_rst", 16'(busy_a), 16'd0);
        end
        prev_a = 16'h0000;
        prev_d = 16'h0000;
        run_sort(16'hB6E9, 1'b0, 16'hEB96, 3'd3, 1'b0, 16'h69BE, 3'd3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
